// File: rtl/regfile_wb_if.sv
// Bundle between the write-back requesters / decode stage and the
// register-file write-back controller.
//
// Handshake: a requester raises req[i] with req_addr/req_data for slot i and
// holds all three stable until it observes gnt[i] high; gnt[i] high in a cycle
// means the write is taken at that cycle's rising edge, and in the following
// cycle the requester may drop req[i] or present its next write.
interface regfile_wb_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req;
  logic [5*NREQ-1:0]    req_addr;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      gnt;
  logic                 we3;
  logic [4:0]           a3;
  logic [31:0]          wd3;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic                 hazard;
  logic [31:0]          pending;

  // Requesters and decode side
  modport master (
    output req, req_addr, req_data, issue_valid, issue_rd, rs1, rs2,
    input  gnt, we3, a3, wd3, hazard, pending
  );

  // Controller side
  modport slave (
    input  req, req_addr, req_data, issue_valid, issue_rd, rs1, rs2,
    output gnt, we3, a3, wd3, hazard, pending
  );
endinterface

// File: rtl/regfile_wb_controller.sv
// Write-back controller for the 32x32 register file: round-robin sharing of
// the single write port among NREQ requesters, a registered write port
// (we3/a3/wd3) and a per-register pending scoreboard for RAW hazard detection.
module regfile_wb_controller #(
  parameter int NREQ = 3
) (
  input logic          clk,
  input logic          reset,
  regfile_wb_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   last;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt_c;
  logic            gnt_any;
  logic [4:0]      sel_addr;
  logic [31:0]     sel_data;
  logic            we3_q;
  logic [4:0]      a3_q;
  logic [31:0]     wd3_q;
  logic [31:0]     pending_q;
  logic [31:0]     pending_nxt;

  // Round-robin search starting one past the last granted requester, wrapping.
  always_comb begin
    gnt_c   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_any && bus.req[i] && (i == (int'(last) + k) % NREQ)) begin
          gnt_c[i] = 1'b1;
          gnt_idx  = IW'(i);
          gnt_any  = 1'b1;
        end
      end
    end
  end

  // Mux the granted requester's address and data onto the write-port inputs.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) begin
        sel_addr = bus.req_addr[5*i +: 5];
        sel_data = bus.req_data[32*i +: 32];
      end
    end
  end

  // Priority pointer: follows every grant, parks at NREQ-1 on reset so that
  // requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= IW'(NREQ - 1);
    end else if (gnt_any) begin
      last <= gnt_idx;
    end
  end

  // Write-port register. A grant to r0 frees the requester but never writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else if (gnt_any) begin
      we3_q <= (sel_addr != 5'd0);
      a3_q  <= sel_addr;
      wd3_q <= sel_data;
    end else begin
      we3_q <= 1'b0;
    end
  end

  // Scoreboard next state: clear on the register-file write, then a new issue
  // to the same register overrides the clear since it is still outstanding.
  always_comb begin
    pending_nxt = pending_q;
    if (we3_q) begin
      pending_nxt[a3_q] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      pending_nxt[bus.issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_nxt;
    end
  end

  // Hazard: any nonzero source register with an unfinished write.
  always_comb begin
    bus.hazard = ((bus.rs1 != 5'd0) && pending_q[bus.rs1]) ||
                 ((bus.rs2 != 5'd0) && pending_q[bus.rs2]);
  end

  assign bus.gnt     = gnt_c;
  assign bus.we3     = we3_q;
  assign bus.a3      = a3_q;
  assign bus.wd3     = wd3_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_regfile_wb_controller.sv
// Bench for regfile_wb_controller: reset, a table of round-robin vectors,
// directed multi-cycle sequences and randomized traffic against a model.
module tb_regfile_wb_controller;

  localparam int NREQ = 3;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  regfile_wb_if #(.NREQ(NREQ)) bus ();

  regfile_wb_controller #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file attached to the write port (r0 not special-cased here so a
  // stray r0 write is visible).
  logic [31:0] dut_rf [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) dut_rf[i] <= '0;
    end else if (bus.we3) begin
      dut_rf[bus.a3] <= bus.wd3;
    end
  end

  // reference model state
  int          m_last;
  logic        m_we3;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  logic [31:0] m_pend;
  logic [2:0]  m_gnt;
  int          m_gidx;

  typedef struct {
    logic [2:0]  req;
    logic [14:0] addr;
    logic [2:0]  exp_gnt;
    logic        exp_we3;
    logic [4:0]  exp_a3;
  } vec_t;
  vec_t tbl [9];

  logic [2:0]  r_req;
  logic [4:0]  r_addr [3];
  logic [31:0] r_data [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.req         = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;
    bus.rs1         = '0;
    bus.rs2         = '0;
  endtask

  task automatic set_one(input int i, input logic [4:0] addr, input logic [31:0] data);
    bus.req[i]              = 1'b1;
    bus.req_addr[5*i +: 5]  = addr;
    bus.req_data[32*i +: 32] = data;
  endtask

  // Model from the rules: search (last+1..last+NREQ) mod NREQ for a requester.
  task automatic sample();
    logic exp_haz;
    @(negedge clk);
    m_gnt  = '0;
    m_gidx = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_last + k) % NREQ;
      if (m_gidx < 0 && bus.req[c]) m_gidx = c;
    end
    if (m_gidx >= 0) m_gnt[m_gidx] = 1'b1;
    exp_haz = ((bus.rs1 != 0) && m_pend[bus.rs1]) || ((bus.rs2 != 0) && m_pend[bus.rs2]);
    chk("gnt", 32'(bus.gnt), 32'(m_gnt));
    chk("hazard", 32'(bus.hazard), 32'(exp_haz));
    chk("we3", 32'(bus.we3), 32'(m_we3));
    chk("a3", 32'(bus.a3), 32'(m_a3));
    chk("wd3", bus.wd3, m_wd3);
    chk("pending", bus.pending, m_pend);
  endtask

  // Advance the model across the coming edge, then step past it.
  task automatic advance();
    logic [31:0] np;
    if (reset) begin
      m_last = NREQ - 1;
      m_we3  = 1'b0;
      m_a3   = '0;
      m_wd3  = '0;
      m_pend = '0;
    end else begin
      np = m_pend;
      if (m_we3) np[m_a3] = 1'b0;
      if (bus.issue_valid && bus.issue_rd != 0) np[bus.issue_rd] = 1'b1;
      np[0] = 1'b0;
      m_pend = np;
      if (m_gidx >= 0) begin
        m_last = m_gidx;
        m_a3   = bus.req_addr[5*m_gidx +: 5];
        m_wd3  = bus.req_data[32*m_gidx +: 32];
        m_we3  = (m_a3 != 0);
      end else begin
        m_we3 = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // table: after reset last=2, so requester 0 first
    tbl[0] = '{3'b111, {5'd3, 5'd2, 5'd1}, 3'b001, 1'b0, 5'd0};
    tbl[1] = '{3'b111, {5'd3, 5'd2, 5'd1}, 3'b010, 1'b1, 5'd1};
    tbl[2] = '{3'b111, {5'd3, 5'd2, 5'd1}, 3'b100, 1'b1, 5'd2};
    tbl[3] = '{3'b111, {5'd3, 5'd2, 5'd1}, 3'b001, 1'b1, 5'd3};
    tbl[4] = '{3'b111, {5'd3, 5'd2, 5'd1}, 3'b010, 1'b1, 5'd1};
    tbl[5] = '{3'b111, {5'd3, 5'd2, 5'd1}, 3'b100, 1'b1, 5'd2};
    tbl[6] = '{3'b010, {5'd0, 5'd0, 5'd0}, 3'b010, 1'b1, 5'd3};
    tbl[7] = '{3'b000, {5'd0, 5'd0, 5'd0}, 3'b000, 1'b0, 5'd0};
    tbl[8] = '{3'b000, {5'd0, 5'd0, 5'd0}, 3'b000, 1'b0, 5'd0};

    m_last = NREQ - 1;
    m_we3  = 1'b0;
    m_a3   = '0;
    m_wd3  = '0;
    m_pend = '0;
    m_gidx = -1;
    m_gnt  = '0;

    // first reset edge brings the DUT out of X; not checked
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // reset held 2 cycles with every requester active
    bus.req = 3'b111;
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("rst_we3", 32'(bus.we3), 32'd0);
      chk("rst_pending", bus.pending, 32'd0);
      chk("rst_hazard", 32'(bus.hazard), 32'd0);
      advance();
    end
    reset = 1'b0;

    // table-driven round-robin and r0 vectors
    for (int r = 0; r < 9; r++) begin
      idle();
      bus.req      = tbl[r].req;
      bus.req_addr = tbl[r].addr;
      for (int i = 0; i < NREQ; i++) bus.req_data[32*i +: 32] = 32'h1000 * r + i;
      sample();
      chk($sformatf("tbl%0d_gnt", r), 32'(bus.gnt), 32'(tbl[r].exp_gnt));
      chk($sformatf("tbl%0d_we3", r), 32'(bus.we3), 32'(tbl[r].exp_we3));
      chk($sformatf("tbl%0d_a3", r), 32'(bus.a3), 32'(tbl[r].exp_a3));
      advance();
    end

    // single write to r5
    idle();
    set_one(1, 5'd5, 32'hDEADBEEF);
    sample();
    chk("sw_gnt", 32'(bus.gnt), 32'(3'b010));
    advance();
    idle();
    sample();
    chk("sw_we3", 32'(bus.we3), 32'd1);
    chk("sw_a3", 32'(bus.a3), 32'd5);
    chk("sw_wd3", bus.wd3, 32'hDEADBEEF);
    advance();
    sample();
    chk("sw_rf5", dut_rf[5], 32'hDEADBEEF);
    advance();

    // write to r0 is granted but never written
    set_one(0, 5'd0, 32'h1234);
    sample();
    chk("r0_gnt", 32'(bus.gnt), 32'(3'b001));
    advance();
    idle();
    sample();
    chk("r0_we3", 32'(bus.we3), 32'd0);
    advance();
    sample();
    chk("r0_rf0", dut_rf[0], 32'd0);
    advance();

    // scoreboard: issue r7, hazard, clear two edges after the grant
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    sample();
    advance();
    idle();
    bus.rs1 = 5'd7;
    sample();
    chk("sb_haz_issue", 32'(bus.hazard), 32'd1);
    advance();
    set_one(2, 5'd7, 32'hAAAA0007);
    sample();
    chk("sb_gnt", 32'(bus.gnt), 32'(3'b100));
    chk("sb_haz_e", 32'(bus.hazard), 32'd1);
    advance();
    idle();
    bus.rs1 = 5'd7;
    sample();
    chk("sb_haz_e1", 32'(bus.hazard), 32'd1);
    chk("sb_we3_e1", 32'(bus.we3), 32'd1);
    advance();
    sample();
    chk("sb_haz_e2", 32'(bus.hazard), 32'd0);
    chk("sb_rf7", dut_rf[7], 32'hAAAA0007);
    advance();

    // set wins over clear on the same register
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    sample();
    advance();
    idle();
    set_one(0, 5'd7, 32'h55);
    sample();
    advance();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    sample();
    chk("sw_clr_we3", 32'(bus.we3), 32'd1);
    chk("sw_clr_a3", 32'(bus.a3), 32'd7);
    advance();
    idle();
    bus.rs2 = 5'd7;
    sample();
    chk("set_wins_pend7", 32'(bus.pending[7]), 32'd1);
    chk("set_wins_haz", 32'(bus.hazard), 32'd1);
    advance();

    // reset while a write to r9 is on the port
    idle();
    set_one(1, 5'd9, 32'h99);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    sample();
    advance();
    idle();
    reset = 1'b1;
    sample();
    chk("mid_we3", 32'(bus.we3), 32'd1);
    chk("mid_a3", 32'(bus.a3), 32'd9);
    advance();
    reset = 1'b0;
    sample();
    chk("mid_we3_after", 32'(bus.we3), 32'd0);
    chk("mid_pend9", 32'(bus.pending[9]), 32'd0);
    chk("mid_rf9", dut_rf[9], 32'd0);
    advance();

    // randomized traffic; requesters hold until granted
    r_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = '0;
      r_data[i] = '0;
    end
    for (int n = 0; n < 400; n++) begin
      reset           = ($urandom_range(0, 63) == 0);
      bus.req         = r_req;
      for (int i = 0; i < NREQ; i++) begin
        bus.req_addr[5*i +: 5]   = r_addr[i];
        bus.req_data[32*i +: 32] = r_data[i];
      end
      bus.issue_valid = ($urandom_range(0, 2) == 0);
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.rs1         = 5'($urandom_range(0, 7));
      bus.rs2         = 5'($urandom_range(0, 7));
      sample();
      for (int i = 0; i < NREQ; i++) begin
        if (!r_req[i] || m_gnt[i]) begin
          r_req[i]  = ($urandom_range(0, 2) != 0);
          r_addr[i] = 5'($urandom_range(0, 7));
          r_data[i] = $urandom;
        end
      end
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_controller.md
# regfile_wb_controller

Write-back controller for the 32×32 register file. Shares the single write port (WE3/A3/WD3) among NREQ write-back requesters with round-robin arbitration. It also keeps a per-register pending scoreboard so decode can detect read-after-write hazards on A1/A2. It sits between the execution units (ALU, memory, mul/div) and the register file.

## Interface
- NREQ, 3, number of write-back requesters (2..4)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state on the next rising edge of clk
- req  in  NREQ  bit i = requester i has a write pending
- req_addr  in  5*NREQ  destination register; requester i owns bits [5i+4:5i]
- req_data  in  32*NREQ  write data (signed); requester i owns bits [32i+31:32i]
- gnt  out  NREQ  one-hot, combinational; bit i high means requester i is accepted this cycle
- we3  out  1  registered write enable to the register file
- a3  out  5  registered write address
- wd3  out  32  registered write data
- issue_valid  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  5  destination of the issuing instruction
- rs1, rs2  in  5 each  source registers being read by decode (the register file's A1/A2)
- hazard  out  1  combinational; a source register has an unfinished write
- pending  out  32  scoreboard vector, one bit per register

## Operation
- Arbitration, combinational:
  - At most one gnt bit is high per cycle.
  - The search starts at requester (last+1) mod NREQ and wraps.
  - The first requester found with req high is granted.
  - If no req bit is high, gnt = 0.
- Handshake:
  - A requester holds req, req_addr and req_data stable until it sees gnt.
  - gnt high in a cycle means the transfer happens at that cycle's rising edge.
  - The requester may drop req, or present its next write, in the following cycle.
- Pointer: last updates to the granted index on every grant and holds when there is no grant. Reset value is NREQ-1, so requester 0 has first priority after reset.
- Write-port register, on a grant at edge E:
  - we3 <= 1 (0 if the granted address is 0), a3 <= granted address, wd3 <= granted data.
  - With no grant: we3 <= 0; a3 and wd3 hold.
- Writes to r0 are still granted, which frees the requester, but they never assert we3.
- Scoreboard, evaluated at each rising edge:
  - Set: issue_valid with issue_rd != 0 sets pending[issue_rd].
  - Clear: we3 high clears pending[a3]. This is the same edge on which the register file stores wd3.
  - Set and clear on the same register in the same cycle: set wins, because the newer instruction is still outstanding.
  - pending[0] is always 0.
- hazard = (rs1 != 0 and pending[rs1]) or (rs2 != 0 and pending[rs2]).
- Reset:
  - Outputs: gnt follows req as for a fresh start; we3 = 0, a3 = 0, wd3 = 0; pending = 0; hazard = 0.
  - Reset in the middle of traffic discards any write captured but not yet performed; that write is lost.

## Timing
- From gnt at edge E: we3/a3/wd3 valid during cycle E+1; the register file writes at edge E+2.
- pending[r] drops at edge E+2. From cycle E+2 on, a read of r returns the new data and hazard for r is 0. There is no bypass path.
- Minimum issue-to-clear time is 2 edges after the first possible grant.
- Throughput: one write per cycle. With k requesters continuously active, each is granted once every k cycles.
- A requester never waits more than NREQ-1 cycles for a grant.

## Test plan
- Reset: hold reset for 2 cycles with all req high -> we3 = 0, pending = 0, hazard = 0. In the first cycle after reset, gnt = 3'b001.
- Single write: req = 3'b010, addr = 5, data = 32'hDEADBEEF -> gnt = 3'b010 in the same cycle; next cycle we3 = 1, a3 = 5, wd3 = DEADBEEF; a later read of r5 returns DEADBEEF.
- Round-robin: all three req held high for 6 cycles -> gnt sequence 001, 010, 100, 001, 010, 100; we3 high for 6 consecutive cycles.
- r0 write: grant with addr = 0, data = 32'h1234 -> gnt asserted, we3 stays 0, r0 reads 0.
- Scoreboard:
  - Issue rd = 7, then set rs1 = 7 -> hazard = 1.
  - Grant a write to 7 at edge E -> hazard stays 1 through cycle E+1 and is 0 at E+2.
  - Issue rd = 7 again in the cycle where we3 = 1 with a3 = 7 -> pending[7] stays 1.
- Reset mid-stream: assert reset in the cycle where we3 = 1 with a3 = 9 -> r9 is not written (register file also reset), we3 = 0, and pending[9] = 0.
